// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one bus slave port among N_MASTERS initiators.
// Each grant runs an address phase then a data phase, each guarded by an optional stall timeout.
module bus_rr_arbiter #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_MASTERS-1:0]        m_valid,
  input  logic [N_MASTERS-1:0]        m_write,
  input  logic [N_MASTERS-1:0]        m_read,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
  output logic [N_MASTERS-1:0]        m_ready,
  output logic [N_MASTERS-1:0]        m_err,
  output logic [DATA_W-1:0]           m_rdata,
  output logic [N_MASTERS-1:0]        grant,
  output logic                        s_valid,
  output logic                        s_write,
  output logic                        s_read,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  input  logic                        s_ready,
  input  logic [DATA_W-1:0]           s_rdata
);

  localparam int unsigned IdxW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned TmrW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       last_q, last_d;
  logic [IdxW-1:0]       win_q, win_d;
  logic [TmrW-1:0]       tmr_q, tmr_d;
  logic [N_MASTERS-1:0]  grant_q, grant_d;
  logic [N_MASTERS-1:0]  m_ready_q, m_ready_d;
  logic [N_MASTERS-1:0]  m_err_q, m_err_d;
  logic [DATA_W-1:0]     m_rdata_q, m_rdata_d;
  logic                  s_write_q, s_write_d;
  logic                  s_read_q, s_read_d;
  logic [ADDR_W-1:0]     s_addr_q, s_addr_d;
  logic [DATA_W-1:0]     s_wdata_q, s_wdata_d;

  logic [N_MASTERS-1:0]  eligible;
  logic                  pick_vld;
  logic [IdxW-1:0]       pick_idx;
  logic [IdxW-1:0]       cand;
  logic                  tmo;
  logic                  done;
  logic                  abort;

  // Command decodes from m_write alone: write wins, anything else is a read.
  logic unused_m_read;
  assign unused_m_read = ^m_read;

  // The master pulsed last cycle may still show m_valid; keep it out of this pick.
  assign eligible = m_valid & ~m_ready_q & ~m_err_q;

  // Scan offsets from farthest to nearest so the nearest eligible after last_q wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = int'(N_MASTERS); k >= 1; k--) begin
      cand = IdxW'((int'(last_q) + k) % int'(N_MASTERS));
      if (eligible[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign tmo = (TIMEOUT != 0) && (tmr_q == TmrW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    tmr_d     = tmr_q;
    grant_d   = grant_q;
    m_ready_d = '0;
    m_err_d   = '0;
    m_rdata_d = m_rdata_q;
    s_write_d = s_write_q;
    s_read_d  = s_read_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    done      = 1'b0;
    abort     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d           = StAddr;
          win_d             = pick_idx;
          tmr_d             = '0;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          s_write_d         = m_write[pick_idx];
          s_read_d          = ~m_write[pick_idx];
          s_addr_d          = m_addr[pick_idx*ADDR_W +: ADDR_W];
          s_wdata_d         = m_wdata[pick_idx*DATA_W +: DATA_W];
        end
      end
      StAddr: begin
        if (s_ready) begin
          state_d = StData;
          tmr_d   = '0;
        end else if (tmo) begin
          abort = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StData: begin
        if (s_ready) begin
          if (s_read_q) m_rdata_d = s_rdata;
          m_ready_d[win_q] = 1'b1;
          done             = 1'b1;
        end else if (tmo) begin
          abort = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (done || abort) begin
      state_d   = StIdle;
      last_d    = win_q;
      tmr_d     = '0;
      grant_d   = '0;
      s_write_d = 1'b0;
      s_read_d  = 1'b0;
      s_addr_d  = '0;
      s_wdata_d = '0;
      if (abort) m_err_d[win_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      last_q    <= IdxW'(N_MASTERS - 1);
      win_q     <= '0;
      tmr_q     <= '0;
      grant_q   <= '0;
      m_ready_q <= '0;
      m_err_q   <= '0;
      m_rdata_q <= '0;
      s_write_q <= 1'b0;
      s_read_q  <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      tmr_q     <= tmr_d;
      grant_q   <= grant_d;
      m_ready_q <= m_ready_d;
      m_err_q   <= m_err_d;
      m_rdata_q <= m_rdata_d;
      s_write_q <= s_write_d;
      s_read_q  <= s_read_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
    end
  end

  assign m_ready = m_ready_q;
  assign m_err   = m_err_q;
  assign m_rdata = m_rdata_q;
  assign grant   = grant_q;
  assign s_valid = (state_q != StIdle);
  assign s_write = s_write_q;
  assign s_read  = s_read_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;

endmodule
